// File: rtl/onewire_rom_responder_if.sv
// Byte-layer link between a 1-Wire bit/byte engine and the command-layer
// responder.
//   rx_byte    byte received from the bus master (valid with byte_done, direction=0)
//   byte_done  one-cycle pulse: receive or transmit byte completed
//   bus_reset  one-cycle pulse: master reset pulse detected
//   direction  0 = receive from master, 1 = transmit to master
//   tx_byte    byte to transmit (valid with tx_strobe)
//   tx_strobe  one-cycle pulse: byte layer loads tx_byte and starts sending
// modport master: byte-layer side; modport slave: command-layer side.
interface onewire_rom_responder_if;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       bus_reset;
  logic       direction;
  logic [7:0] tx_byte;
  logic       tx_strobe;

  modport master (
    output rx_byte, byte_done, bus_reset,
    input  direction, tx_byte, tx_strobe
  );

  modport slave (
    input  rx_byte, byte_done, bus_reset,
    output direction, tx_byte, tx_strobe
  );
endinterface

// File: rtl/onewire_rom_responder.sv
// 1-Wire slave command layer: Read ROM (0x33), Match ROM (0x55) and Skip ROM
// (0xCC) against ROM_ID, then function command Read Data (0xBE) returning a
// snapshot of data_in followed by its Dallas CRC8.
//   clk        system clock, rising edge
//   reset      asynchronous, active-low
//   bus        byte-layer link (slave modport)
//   data_in    payload, byte j = data_in[8j+7:8j]
//   selected   device addressed since the last bus_reset
//   cmd_error  one-cycle pulse on an unknown ROM or function command
module onewire_rom_responder #(
  parameter logic [63:0] ROM_ID     = 64'hF1DEBC9A78563412,
  parameter int unsigned DATA_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  onewire_rom_responder_if.slave  bus,
  input  logic [8*DATA_BYTES-1:0] data_in,
  output logic                    selected,
  output logic                    cmd_error
);

  localparam int unsigned IW = $clog2((DATA_BYTES + 1 > 8) ? DATA_BYTES + 1 : 8);
  localparam logic [IW-1:0] LAST_ROM = IW'(7);
  localparam logic [IW-1:0] LAST_PAY = IW'(DATA_BYTES - 1);
  localparam logic [IW-1:0] CRC_IDX  = IW'(DATA_BYTES);

  typedef enum logic [2:0] {
    WAIT_RESET,
    ROM_CMD,
    READ_ROM,
    MATCH_ROM,
    FUNC_CMD,
    READ_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic                    direction_q, direction_d;
  logic [7:0]              tx_byte_q, tx_byte_d;
  logic                    tx_strobe_q, tx_strobe_d;
  logic                    selected_q, selected_d;
  logic                    cmd_error_q, cmd_error_d;
  logic [IW-1:0]           index_q, index_d;
  logic [7:0]              crc_q, crc_d;
  logic [8*DATA_BYTES-1:0] buffer_q, buffer_d;
  logic [IW-1:0]           index_inc;
  logic [7:0]              next_payload;
  logic                    rom_match;

  function automatic logic [7:0] rom_byte(input logic [IW-1:0] i);
    return ROM_ID[{i[2:0], 3'b000} +: 8];
  endfunction

  // Dallas CRC8, reflected polynomial 0x8C, LSB first.
  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  assign index_inc    = index_q + 1'b1;
  assign next_payload = buffer_q[8*int'(index_inc) +: 8];
  assign rom_match    = (bus.rx_byte == rom_byte(index_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_RESET;
      direction_q <= 1'b0;
      tx_byte_q   <= '0;
      tx_strobe_q <= 1'b0;
      selected_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      index_q     <= '0;
      crc_q       <= '0;
      buffer_q    <= '0;
    end else begin
      state_q     <= state_d;
      direction_q <= direction_d;
      tx_byte_q   <= tx_byte_d;
      tx_strobe_q <= tx_strobe_d;
      selected_q  <= selected_d;
      cmd_error_q <= cmd_error_d;
      index_q     <= index_d;
      crc_q       <= crc_d;
      buffer_q    <= buffer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.bus_reset) begin
      state_d = ROM_CMD;
    end else if (bus.byte_done) begin
      unique case (state_q)
        WAIT_RESET: state_d = WAIT_RESET;
        ROM_CMD: begin
          unique case (bus.rx_byte)
            8'h33:   state_d = READ_ROM;
            8'h55:   state_d = MATCH_ROM;
            8'hCC:   state_d = FUNC_CMD;
            default: state_d = WAIT_RESET;
          endcase
        end
        READ_ROM:  if (index_q == LAST_ROM) state_d = FUNC_CMD;
        MATCH_ROM: begin
          if (!rom_match)                  state_d = WAIT_RESET;
          else if (index_q == LAST_ROM)    state_d = FUNC_CMD;
        end
        FUNC_CMD:  state_d = (bus.rx_byte == 8'hBE) ? READ_DATA : WAIT_RESET;
        READ_DATA: if (index_q == CRC_IDX) state_d = WAIT_RESET;
        default:   state_d = WAIT_RESET;
      endcase
    end
  end

  // The CRC is folded in as each payload byte is issued, so it is complete
  // by the time the last payload byte's byte_done asks for the CRC byte,
  // even with byte_done pulses on consecutive cycles.
  always_comb begin
    direction_d = direction_q;
    tx_byte_d   = tx_byte_q;
    tx_strobe_d = 1'b0;
    selected_d  = selected_q;
    cmd_error_d = 1'b0;
    index_d     = index_q;
    crc_d       = crc_q;
    buffer_d    = buffer_q;
    if (bus.bus_reset) begin
      direction_d = 1'b0;
      selected_d  = 1'b0;
      index_d     = '0;
    end else if (bus.byte_done) begin
      unique case (state_q)
        WAIT_RESET: ;
        ROM_CMD: begin
          unique case (bus.rx_byte)
            8'h33: begin
              direction_d = 1'b1;
              tx_byte_d   = rom_byte('0);
              tx_strobe_d = 1'b1;
              index_d     = '0;
            end
            8'h55:   index_d     = '0;
            8'hCC:   selected_d  = 1'b1;
            default: cmd_error_d = 1'b1;
          endcase
        end
        READ_ROM: begin
          if (index_q == LAST_ROM) begin
            direction_d = 1'b0;
            selected_d  = 1'b1;
          end else begin
            index_d     = index_inc;
            tx_byte_d   = rom_byte(index_inc);
            tx_strobe_d = 1'b1;
          end
        end
        MATCH_ROM: begin
          if (rom_match) begin
            if (index_q == LAST_ROM) selected_d = 1'b1;
            else                     index_d    = index_inc;
          end
        end
        FUNC_CMD: begin
          if (bus.rx_byte == 8'hBE) begin
            buffer_d    = data_in;
            index_d     = '0;
            direction_d = 1'b1;
            tx_byte_d   = data_in[7:0];
            tx_strobe_d = 1'b1;
            crc_d       = crc8(8'h00, data_in[7:0]);
          end else begin
            cmd_error_d = 1'b1;
          end
        end
        READ_DATA: begin
          if (index_q == CRC_IDX) begin
            direction_d = 1'b0;
          end else if (index_q == LAST_PAY) begin
            index_d     = index_inc;
            tx_byte_d   = crc_q;
            tx_strobe_d = 1'b1;
          end else begin
            index_d     = index_inc;
            tx_byte_d   = next_payload;
            tx_strobe_d = 1'b1;
            crc_d       = crc8(crc_q, next_payload);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.direction = direction_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_strobe = tx_strobe_q;
  assign selected      = selected_q;
  assign cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_onewire_rom_responder.sv
// Self-checking bench for onewire_rom_responder (DATA_BYTES=7, default ROM_ID).
// Expected transmit bytes are queued as stimulus is driven; a negedge monitor
// pops and compares them whenever tx_strobe is seen.
module tb_onewire_rom_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [55:0] data_in = '0;
  logic        selected;
  logic        cmd_error;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_byte;
  logic [7:0]  rom_bytes[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};

  always #5 clk = ~clk;

  onewire_rom_responder_if bus ();

  onewire_rom_responder #(
    .ROM_ID(64'hF1DEBC9A78563412),
    .DATA_BYTES(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .data_in(data_in),
    .selected(selected),
    .cmd_error(cmd_error)
  );

  function automatic logic [7:0] model_crc(input logic [55:0] d);
    logic [7:0] c;
    logic [7:0] b;
    logic       fb;
    c = 8'h00;
    for (int j = 0; j < 7; j++) begin
      b = d[8*j +: 8];
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.tx_strobe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: tx_byte=%h direction=%b, expected no strobe", bus.tx_byte, bus.direction);
      end else begin
        exp_byte = exp_q.pop_front();
        if (bus.tx_byte !== exp_byte || bus.direction !== 1'b1) begin
          failures++;
          $display("FAIL tx_byte: got %h dir=%b, expected %h dir=1", bus.tx_byte, bus.direction, exp_byte);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte   = b;
    bus.byte_done = 1'b1;
    @(negedge clk);
    bus.byte_done = 1'b0;
  endtask

  task automatic pulse_bus_reset();
    @(negedge clk);
    bus.bus_reset = 1'b1;
    @(negedge clk);
    bus.bus_reset = 1'b0;
  endtask

  task automatic random_data(output logic [55:0] d);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    d = r[55:0];
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.direction, bus.tx_strobe, selected, cmd_error, bus.tx_byte} !== 12'h000) begin
      failures++;
      $display("FAIL reset_values: dir=%b strobe=%b sel=%b err=%b tx=%h, expected all 0",
               bus.direction, bus.tx_strobe, selected, cmd_error, bus.tx_byte);
    end
    reset = 1'b1;
    tick_byte(8'h33);
    checks++;
    if (bus.direction !== 1'b0 || selected !== 1'b0) begin
      failures++;
      $display("FAIL wait_reset_ignore: dir=%b sel=%b, expected 0 0", bus.direction, selected);
    end
  endtask

  task automatic test_read_rom();
    pulse_bus_reset();
    exp_q.push_back(rom_bytes[0]);
    tick_byte(8'h33);
    checks++;
    if (bus.tx_strobe !== 1'b1 || bus.direction !== 1'b1) begin
      failures++;
      $display("FAIL rr_first_strobe: strobe=%b dir=%b, expected 1 1", bus.tx_strobe, bus.direction);
    end
    @(negedge clk);
    checks++;
    if (bus.tx_strobe !== 1'b0) begin
      failures++;
      $display("FAIL rr_strobe_width: strobe=%b, expected 0", bus.tx_strobe);
    end
    for (int k = 1; k < 8; k++) begin
      exp_q.push_back(rom_bytes[k]);
      tick_byte(8'h00);
      checks++;
      if (bus.tx_strobe !== 1'b1) begin
        failures++;
        $display("FAIL rr_next_strobe: byte %0d strobe=%b, expected 1", k, bus.tx_strobe);
      end
    end
    tick_byte(8'h00);
    checks++;
    if (bus.direction !== 1'b0 || bus.tx_strobe !== 1'b0 || selected !== 1'b1) begin
      failures++;
      $display("FAIL rr_done: dir=%b strobe=%b sel=%b, expected 0 0 1", bus.direction, bus.tx_strobe, selected);
    end
  endtask

  task automatic test_match_read_data();
    logic [7:0]  vec[8] = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
    logic [55:0] junk;
    pulse_bus_reset();
    tick_byte(8'h55);
    for (int k = 0; k < 8; k++) begin
      tick_byte(rom_bytes[k]);
      if (k == 6) begin
        checks++;
        if (selected !== 1'b0) begin
          failures++;
          $display("FAIL match_early_select: sel=%b, expected 0", selected);
        end
      end
    end
    checks++;
    if (selected !== 1'b1) begin
      failures++;
      $display("FAIL match_select: sel=%b, expected 1", selected);
    end
    data_in = 56'h00000001B81C02;
    for (int k = 0; k < 8; k++) exp_q.push_back(vec[k]);
    tick_byte(8'hBE);
    random_data(junk);
    data_in = junk;
    checks++;
    if (bus.tx_strobe !== 1'b1 || bus.direction !== 1'b1) begin
      failures++;
      $display("FAIL rd_first_strobe: strobe=%b dir=%b, expected 1 1", bus.tx_strobe, bus.direction);
    end
    for (int k = 1; k < 8; k++) begin
      tick_byte(8'h00);
      checks++;
      if (bus.tx_strobe !== 1'b1) begin
        failures++;
        $display("FAIL rd_next_strobe: byte %0d strobe=%b, expected 1", k, bus.tx_strobe);
      end
    end
    tick_byte(8'h00);
    checks++;
    if (bus.direction !== 1'b0 || bus.tx_strobe !== 1'b0) begin
      failures++;
      $display("FAIL rd_done: dir=%b strobe=%b, expected 0 0", bus.direction, bus.tx_strobe);
    end
    tick_byte(8'hBE);
    checks++;
    if (selected !== 1'b1 || bus.direction !== 1'b0) begin
      failures++;
      $display("FAIL rd_after_wait: sel=%b dir=%b, expected 1 0", selected, bus.direction);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  seq[10];
    logic [55:0] d;
    logic [55:0] junk;
    random_data(d);
    data_in = d;
    seq[0] = 8'h55;
    for (int k = 0; k < 8; k++) seq[k+1] = rom_bytes[k];
    seq[9] = 8'hBE;
    for (int k = 0; k < 7; k++) exp_q.push_back(d[8*k +: 8]);
    exp_q.push_back(model_crc(d));
    pulse_bus_reset();
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      bus.rx_byte   = seq[k];
      bus.byte_done = 1'b1;
      @(negedge clk);
    end
    random_data(junk);
    data_in = junk;
    bus.rx_byte = 8'h00;
    repeat (8) @(negedge clk);
    bus.byte_done = 1'b0;
    checks++;
    if (bus.direction !== 1'b0 || selected !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done: dir=%b sel=%b, expected 0 1", bus.direction, selected);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: %0d bytes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_mismatch();
    pulse_bus_reset();
    tick_byte(8'h55);
    for (int k = 0; k < 3; k++) tick_byte(rom_bytes[k]);
    tick_byte(8'h00);
    checks++;
    if (selected !== 1'b0 || cmd_error !== 1'b0) begin
      failures++;
      $display("FAIL mismatch: sel=%b err=%b, expected 0 0", selected, cmd_error);
    end
    for (int k = 4; k < 8; k++) tick_byte(rom_bytes[k]);
    tick_byte(8'hBE);
    tick_byte(8'h33);
    checks++;
    if (selected !== 1'b0 || bus.direction !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_ignore: sel=%b dir=%b, expected 0 0", selected, bus.direction);
    end
  endtask

  task automatic test_cmd_error();
    pulse_bus_reset();
    tick_byte(8'hF0);
    checks++;
    if (cmd_error !== 1'b1) begin
      failures++;
      $display("FAIL rom_cmd_error: err=%b, expected 1", cmd_error);
    end
    @(negedge clk);
    checks++;
    if (cmd_error !== 1'b0) begin
      failures++;
      $display("FAIL rom_cmd_error_width: err=%b, expected 0", cmd_error);
    end
    tick_byte(8'h33);
    checks++;
    if (bus.direction !== 1'b0 || selected !== 1'b0) begin
      failures++;
      $display("FAIL rom_err_wait: dir=%b sel=%b, expected 0 0", bus.direction, selected);
    end
    pulse_bus_reset();
    tick_byte(8'hCC);
    checks++;
    if (selected !== 1'b1 || cmd_error !== 1'b0) begin
      failures++;
      $display("FAIL skip_select: sel=%b err=%b, expected 1 0", selected, cmd_error);
    end
    tick_byte(8'h44);
    checks++;
    if (cmd_error !== 1'b1) begin
      failures++;
      $display("FAIL func_cmd_error: err=%b, expected 1", cmd_error);
    end
    @(negedge clk);
    checks++;
    if (cmd_error !== 1'b0) begin
      failures++;
      $display("FAIL func_cmd_error_width: err=%b, expected 0", cmd_error);
    end
    tick_byte(8'hBE);
    checks++;
    if (bus.direction !== 1'b0) begin
      failures++;
      $display("FAIL func_err_wait: dir=%b, expected 0", bus.direction);
    end
  endtask

  task automatic test_bus_reset_abort();
    logic [55:0] d;
    random_data(d);
    data_in = d;
    pulse_bus_reset();
    tick_byte(8'hCC);
    exp_q.push_back(d[7:0]);
    tick_byte(8'hBE);
    exp_q.push_back(d[15:8]);
    tick_byte(8'h00);
    exp_q.push_back(d[23:16]);
    tick_byte(8'h00);
    @(negedge clk);
    bus.bus_reset = 1'b1;
    bus.byte_done = 1'b1;
    @(negedge clk);
    bus.bus_reset = 1'b0;
    bus.byte_done = 1'b0;
    checks++;
    if (bus.direction !== 1'b0 || bus.tx_strobe !== 1'b0 || selected !== 1'b0) begin
      failures++;
      $display("FAIL abort: dir=%b strobe=%b sel=%b, expected 0 0 0", bus.direction, bus.tx_strobe, selected);
    end
    tick_byte(8'hCC);
    checks++;
    if (selected !== 1'b1) begin
      failures++;
      $display("FAIL abort_rom_cmd: sel=%b, expected 1", selected);
    end
  endtask

  task automatic test_async_reset();
    pulse_bus_reset();
    exp_q.push_back(rom_bytes[0]);
    tick_byte(8'h33);
    exp_q.push_back(rom_bytes[1]);
    tick_byte(8'h00);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.direction, bus.tx_strobe, selected, cmd_error, bus.tx_byte} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset: dir=%b strobe=%b sel=%b err=%b tx=%h, expected all 0",
               bus.direction, bus.tx_strobe, selected, cmd_error, bus.tx_byte);
    end
    @(negedge clk);
    reset = 1'b1;
    tick_byte(8'h33);
    tick_byte(8'h00);
    tick_byte(8'hCC);
    checks++;
    if (selected !== 1'b0 || bus.direction !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_ignore: sel=%b dir=%b, expected 0 0", selected, bus.direction);
    end
    pulse_bus_reset();
    tick_byte(8'hCC);
    checks++;
    if (selected !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_recover: sel=%b, expected 1", selected);
    end
  endtask

  initial begin
    bus.rx_byte   = 8'h00;
    bus.byte_done = 1'b0;
    bus.bus_reset = 1'b0;
    test_reset();
    test_read_rom();
    test_match_read_data();
    test_back_to_back();
    test_mismatch();
    test_cmd_error();
    test_bus_reset_abort();
    test_async_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d bytes outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/onewire_rom_responder.md
# onewire_rom_responder

Parametrised 1-Wire slave command layer sitting directly above the bit/byte layer, in place of the fixed Read-ROM-only responder. Implements ROM commands Read ROM (0x33), Match ROM (0x55) and Skip ROM (0xCC) against a parameter-supplied 64-bit ROM ID. After a device is selected it accepts the function command Read Data (0xBE): it returns DATA_BYTES bytes snapshotted from a parallel input, followed by a Dallas CRC8. Fully synchronous to clk; all byte-layer events arrive as single-cycle pulses.

## Interface
- ROM_ID, 64'hF1DEBC9A78563412, device ROM ID; byte k = ROM_ID[8k+7:8k], transmitted and matched byte 0 first.
- DATA_BYTES, 8, payload length for Read Data; legal range 1..32.
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low; asserted (0) forces reset values immediately.
- rx_byte  in  8  byte received from master; valid in the cycle byte_done=1 while direction=0.
- byte_done  in  1  one-cycle pulse from byte layer: a receive (direction=0) or transmit (direction=1) byte completed.
- bus_reset  in  1  one-cycle pulse: byte layer detected a master reset pulse.
- data_in  in  8*DATA_BYTES  payload; byte j = data_in[8j+7:8j].
- direction  out  1  0 = receive from master, 1 = transmit to master.
- tx_byte  out  8  byte to transmit; valid with tx_strobe.
- tx_strobe  out  1  one-cycle pulse: byte layer loads tx_byte and starts transmitting.
- selected  out  1  device addressed (Skip, matched Match, or completed Read ROM) since last bus_reset.
- cmd_error  out  1  one-cycle pulse on unknown ROM or function command.

## Operation
- States: WAIT_RESET, ROM_CMD, READ_ROM, MATCH_ROM, FUNC_CMD, READ_DATA.
- Reset values: state=WAIT_RESET, direction=0, tx_byte=0, tx_strobe=0, selected=0, cmd_error=0, index=0, crc=0.
- bus_reset in any state: state=ROM_CMD, direction=0, selected=0, index=0. It takes priority over a simultaneous byte_done, and an in-flight transmit is abandoned.
- WAIT_RESET: ignores byte_done; leaves only on bus_reset.
- ROM_CMD, on byte_done:
  - 0x33: enter READ_ROM and transmit ROM byte 0.
  - 0x55: enter MATCH_ROM with index=0.
  - 0xCC: selected=1, enter FUNC_CMD.
  - Other: cmd_error pulse, enter WAIT_RESET.
- READ_ROM: each transmit byte_done advances index and transmits the next ROM byte. After byte 7 completes: direction=0, selected=1, enter FUNC_CMD.
- MATCH_ROM: each byte_done compares rx_byte with ROM byte index.
  - Mismatch: enter WAIT_RESET, selected stays 0, no cmd_error.
  - Byte 7 matches: selected=1, enter FUNC_CMD.
- FUNC_CMD, on byte_done:
  - 0xBE: snapshot data_in into an internal buffer in that same cycle, set crc=0, enter READ_DATA and transmit payload byte 0.
  - Other: cmd_error pulse, enter WAIT_RESET.
- READ_DATA: transmits buffer bytes 0..DATA_BYTES-1, then the CRC byte.
  - On each tx_strobe carrying a payload byte, crc is updated with that byte: Dallas CRC8, polynomial x^8+x^5+x^4+1, reflected 0x8C, LSB first, init 0x00.
  - The CRC byte itself is not folded into crc.
  - After the CRC byte's byte_done: direction=0, enter WAIT_RESET.
- data_in changes after the snapshot do not affect the transfer in progress.
- index width: clog2(max(8, DATA_BYTES+1)); never wraps within a transfer.

## Timing
- Any receive byte_done at cycle N that starts a transmit (0x33 or 0xBE): at N+1 direction=1, tx_byte=first byte, tx_strobe=1 for exactly cycle N+1.
- Transmit byte_done at N with more bytes to send: at N+1 tx_byte=next byte, tx_strobe=1.
- Last transmit byte_done at N: direction=0 at N+1, no tx_strobe.
- State changes, selected and cmd_error are all registered: a transition caused by an event at N is visible at N+1. cmd_error is high for cycle N+1 only.
- tx_strobe is never asserted without a causing byte_done, and never while direction=0.
- Back-to-back byte_done pulses on consecutive cycles must be handled with no lost events.
- reset deassertion mid-transfer: the block resumes from reset values in WAIT_RESET.

## Test plan
- Default ROM_ID: bus_reset, rx 0x33 -> tx_strobe bytes 12 34 56 78 9A BC DE F1, each one cycle after the previous byte_done. Then selected=1 and direction=0.
- bus_reset, rx 0x55 followed by the 8 ROM bytes -> selected=1. Then rx 0xBE with DATA_BYTES=7 and data_in bytes 02 1C B8 01 00 00 00 -> tx 02 1C B8 01 00 00 00 A2.
- bus_reset, 0x55 with byte 3 = 0x00 -> selected stays 0, no tx_strobe. Subsequent byte_done pulses are ignored until the next bus_reset.
- bus_reset, rx 0xF0 -> cmd_error single pulse, WAIT_RESET. Repeat with 0xCC then function byte 0x44 -> cmd_error pulse.
- bus_reset during READ_DATA byte 2, with byte_done in the same cycle -> next cycle state=ROM_CMD, direction=0, selected=0, no tx_strobe.
- reset=0 asserted mid-READ_ROM -> all outputs at reset values immediately. After release, byte_done pulses are ignored until bus_reset.
